// File: rtl/match_link_syncer_pkg.sv
// match_link_syncer_pkg: shared types, frame constants and checksum helper for the board-to-board link syncer.
package match_link_syncer_pkg;
   typedef logic [88:0] data_t;
   localparam data_t DATA_T_DEFAULT = '0;
   localparam int FRAME_BYTES = 14;
   localparam int PAYLOAD_BYTES = 12;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CSUM} tx_state_t;
   typedef enum logic [1:0] {RX_HUNT, RX_PAYLOAD, RX_CHECK} rx_state_t;
   function automatic logic [7:0] payload_xor(input logic [95:0] w);
      logic [7:0] x;
      x = '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) x ^= w[8*i +: 8];
      return x;
   endfunction
endpackage

// File: rtl/match_link_syncer_frame_deframer.sv
// match_link_syncer_frame_deframer: hunts for the sync byte, shifts in the LSB-first payload and checks the XOR checksum.
module match_link_syncer_frame_deframer
   import match_link_syncer_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic        clk_pixel_in,
   input  logic        rst_in,
   input  logic [7:0]  rx_byte_in,
   input  logic        rx_valid_in,
   output logic [89:0] word,
   output logic        good,
   output logic        bad
);
   rx_state_t state, state_n;
   logic [95:0] sh;
   logic [7:0] acc;
   logic [3:0] cnt;
   logic check;
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         state <= RX_HUNT;
         sh <= '0;
         acc <= '0;
         cnt <= '0;
      end else begin
         state <= state_n;
         if (rx_valid_in && state == RX_HUNT) begin
            acc <= '0;
            cnt <= '0;
         end else if (rx_valid_in && state == RX_PAYLOAD) begin
            sh <= {rx_byte_in, sh[95:8]};
            acc <= acc ^ rx_byte_in;
            cnt <= cnt + 4'd1;
         end
      end
   end
   always_comb begin
      state_n = !rx_valid_in ? state :
                state == RX_HUNT ? (rx_byte_in == SYNC_BYTE ? RX_PAYLOAD : RX_HUNT) :
                state == RX_PAYLOAD ? (cnt == 4'(PAYLOAD_BYTES - 1) ? RX_CHECK : RX_PAYLOAD) :
                RX_HUNT;
   end
   // Nonzero pad bits mark a malformed frame even when the checksum agrees.
   always_comb begin
      check = state == RX_CHECK && rx_valid_in;
      good = check && rx_byte_in == acc && sh[95:90] == 6'b0;
      bad = check && !(rx_byte_in == acc && sh[95:90] == 6'b0);
      word = sh[89:0];
   end
endmodule

// File: rtl/match_link_syncer.sv
// match_link_syncer: frames local player state onto a byte link and accepts checked opponent frames; tracks link liveness.
// Optional SYNC_ERR_CNT_EN adds a saturating bad-frame counter output.
module match_link_syncer
   import match_link_syncer_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_500_000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic        clk_pixel_in,
   input  logic        rst_in,
   input  data_t       player_data_in,
   input  logic        player_scored_in,
   input  logic        player_data_valid_in,
   output logic [7:0]  tx_byte_out,
   output logic        tx_valid_out,
   input  logic        tx_ready_in,
   input  logic [7:0]  rx_byte_in,
   input  logic        rx_valid_in,
   output data_t       opponent_data_out,
   output logic        opponent_scored_out,
   output logic        syncer_out_valid,
   output logic        link_up_out
`ifdef SYNC_ERR_CNT_EN
   ,
   output logic [15:0] rx_err_count_out
`endif
);
   tx_state_t tx_state, tx_state_n;
   logic [89:0] pend_buf;
   logic pend;
   logic [95:0] tx_sh;
   logic [7:0] tx_csum;
   logic [3:0] idx;
   logic hs;
   assign hs = tx_valid_out && tx_ready_in;
   // The frame in flight lives in tx_sh/tx_csum, so new strobes only touch the pending buffer.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         tx_state <= TX_IDLE;
         pend_buf <= '0;
         pend <= 1'b0;
         tx_sh <= '0;
         tx_csum <= '0;
         idx <= '0;
      end else begin
         tx_state <= tx_state_n;
         if (player_data_valid_in) pend_buf <= {player_scored_in, player_data_in};
         pend <= player_data_valid_in || (pend && tx_state != TX_IDLE);
         if (tx_state == TX_IDLE && pend) begin
            tx_sh <= {6'b0, pend_buf};
            tx_csum <= payload_xor({6'b0, pend_buf});
            idx <= '0;
         end else if (tx_state == TX_SEND && hs) begin
            idx <= idx + 4'd1;
            if (idx != 4'd0) tx_sh <= {8'h00, tx_sh[95:8]};
         end
      end
   end
   always_comb begin
      tx_state_n = tx_state == TX_IDLE ? (pend ? TX_SEND : TX_IDLE) :
                   tx_state == TX_SEND ? (hs && idx == 4'(FRAME_BYTES - 2) ? TX_CSUM : TX_SEND) :
                   (hs ? TX_IDLE : TX_CSUM);
   end
   always_comb begin
      tx_valid_out = tx_state != TX_IDLE;
      tx_byte_out = tx_state == TX_IDLE ? 8'h00 :
                    tx_state == TX_CSUM ? tx_csum :
                    idx == 4'd0 ? SYNC_BYTE : tx_sh[7:0];
   end
   logic [89:0] rx_word;
   logic good, bad;
   logic [23:0] tmo, tmo_n;
   match_link_syncer_frame_deframer #(.SYNC_BYTE(SYNC_BYTE)) u_deframer (
      .clk_pixel_in(clk_pixel_in),
      .rst_in(rst_in),
      .rx_byte_in(rx_byte_in),
      .rx_valid_in(rx_valid_in),
      .word(rx_word),
      .good(good),
      .bad(bad)
   );
   assign tmo_n = good ? 24'd0 : tmo == TIMEOUT_CYCLES ? tmo : tmo + 24'd1;
   // A good frame in the saturation cycle keeps the link up.
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
         opponent_data_out <= DATA_T_DEFAULT;
         opponent_scored_out <= 1'b0;
         syncer_out_valid <= 1'b0;
         link_up_out <= 1'b0;
         tmo <= '0;
      end else begin
         syncer_out_valid <= good;
         if (good) begin
            opponent_data_out <= rx_word[88:0];
            opponent_scored_out <= rx_word[89];
         end
         tmo <= tmo_n;
         link_up_out <= good || (link_up_out && tmo_n != TIMEOUT_CYCLES);
      end
   end
`ifdef SYNC_ERR_CNT_EN
   always_ff @(posedge clk_pixel_in) begin
      if (rst_in) rx_err_count_out <= '0;
      else if (bad && rx_err_count_out != 16'hFFFF) rx_err_count_out <= rx_err_count_out + 16'd1;
   end
`else
   logic unused_bad;
   assign unused_bad = bad;
`endif
endmodule

// File: tb/tb_match_link_syncer.sv
// tb_match_link_syncer: directed loopback/injection bench with a received-frame scoreboard.
module tb_match_link_syncer;
   import match_link_syncer_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;
   data_t pdata = '0;
   logic pscored = 1'b0, pvalid = 1'b0, tx_ready = 1'b1;
   logic [7:0] tx_byte, rx_byte;
   logic [7:0] inj_byte = 8'h00;
   logic tx_valid, rx_valid;
   logic inj_valid = 1'b0, loop = 1'b0;
   data_t odata;
   logic oscored, ovalid, link_up;
`ifdef SYNC_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif
   assign rx_byte = loop ? tx_byte : inj_byte;
   assign rx_valid = loop ? (tx_valid && tx_ready) : inj_valid;

   match_link_syncer #(.TIMEOUT_CYCLES(24'd100), .SYNC_BYTE(8'hA5)) dut (
      .clk_pixel_in(clk),
      .rst_in(rst),
      .player_data_in(pdata),
      .player_scored_in(pscored),
      .player_data_valid_in(pvalid),
      .tx_byte_out(tx_byte),
      .tx_valid_out(tx_valid),
      .tx_ready_in(tx_ready),
      .rx_byte_in(rx_byte),
      .rx_valid_in(rx_valid),
      .opponent_data_out(odata),
      .opponent_scored_out(oscored),
      .syncer_out_valid(ovalid),
      .link_up_out(link_up)
`ifdef SYNC_ERR_CNT_EN
      ,
      .rx_err_count_out(err_cnt)
`endif
   );

   int vecs = 0, errs = 0, pulses = 0;
   logic [89:0] exp_q[$];
   logic [7:0] txq[$];

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fbyte(input logic [95:0] p, input int i);
      logic [7:0] x = 8'h00;
      if (i == 0) return 8'hA5;
      if (i == 13) begin
         for (int k = 0; k < 12; k++) x ^= p[8*k +: 8];
         return x;
      end
      return p[8*(i-1) +: 8];
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [89:0] w);
      pdata = w[88:0];
      pscored = w[89];
      pvalid = 1'b1;
      step(1);
      pvalid = 1'b0;
   endtask

   task automatic send(input logic [95:0] p, input int nbytes, input logic bad_csum);
      for (int i = 0; i < nbytes; i++) begin
         inj_byte = fbyte(p, i) ^ ((bad_csum && i == 13) ? 8'hFF : 8'h00);
         inj_valid = 1'b1;
         step(1);
         inj_valid = 1'b0;
         step(1);
      end
   endtask

   task automatic wait_bytes(input int n, input int bound);
      for (int i = 0; i < bound && txq.size() < n; i++) step(1);
      chk("tx_bytes_reached", 96'(txq.size() >= n), 96'd1);
   endtask

   task automatic chk_frame(input int base, input logic [89:0] w);
      for (int i = 0; i < 14; i++)
         chk($sformatf("tx_byte[%0d]", base + i), 96'(txq[base+i]), 96'(fbyte({6'b0, w}, i)));
   endtask

   // Scoreboard side: every pulse must match the oldest outstanding expected word.
   always @(negedge clk) begin
      if (tx_valid && tx_ready) txq.push_back(tx_byte);
      if (ovalid) begin
         pulses++;
         chk("pulse_expected", 96'(exp_q.size() > 0), 96'd1);
         if (exp_q.size() > 0) chk("rx_word", 96'({oscored, odata}), 96'(exp_q.pop_front()));
      end
   end

   initial begin
      logic [89:0] wa, wb, wc, wd;
      logic [95:0] p2, p3, p5;
      logic [7:0] b0;
      logic v0, changed;
      int n;
      step(3);
      chk("rst_tx_valid", 96'(tx_valid), 96'd0);
      chk("rst_tx_byte", 96'(tx_byte), 96'd0);
      chk("rst_odata", 96'(odata), 96'(DATA_T_DEFAULT));
      chk("rst_oscored", 96'(oscored), 96'd0);
      chk("rst_ovalid", 96'(ovalid), 96'd0);
      chk("rst_link_up", 96'(link_up), 96'd0);
`ifdef SYNC_ERR_CNT_EN
      chk("rst_err_cnt", 96'(err_cnt), 96'd0);
`endif
      rst = 1'b0;
      step(2);
      // Loopback of a single update.
      loop = 1'b1;
      tx_ready = 1'b1;
      txq.delete();
      wa = {1'b1, DATA_T_DEFAULT ^ 89'h1};
      exp_q.push_back(wa);
      strobe(wa);
      wait_bytes(14, 100);
      chk_frame(0, wa);
      step(4);
      chk("loop_pulses", 96'(pulses), 96'd1);
      chk("loop_odata", 96'(odata), 96'(wa[88:0]));
      chk("loop_oscored", 96'(oscored), 96'd1);
      chk("loop_link_up", 96'(link_up), 96'd1);
      // Corrupted checksum, then nonzero pad bits: both dropped.
      loop = 1'b0;
      p2 = {6'b0, 1'b0, 89'h0_1234_5678_9ABC_DEF0_1357};
      send(p2, 14, 1'b1);
      step(3);
      chk("badcsum_pulses", 96'(pulses), 96'd1);
      chk("badcsum_odata", 96'(odata), 96'(wa[88:0]));
      chk("badcsum_oscored", 96'(oscored), 96'd1);
`ifdef SYNC_ERR_CNT_EN
      chk("badcsum_err_cnt", 96'(err_cnt), 96'd1);
`endif
      send({6'b000001, p2[89:0]}, 14, 1'b0);
      step(3);
      chk("pad_pulses", 96'(pulses), 96'd1);
      chk("pad_odata", 96'(odata), 96'(wa[88:0]));
`ifdef SYNC_ERR_CNT_EN
      chk("pad_err_cnt", 96'(err_cnt), 96'd2);
`endif
      // Sync-byte values inside the payload are plain data.
      p3 = {6'b0, 1'b0, 89'h0_A5A5_A5A5_00A5_1122_A5A5};
      exp_q.push_back(p3[89:0]);
      send(p3, 14, 1'b0);
      step(3);
      chk("sync_in_payload_pulses", 96'(pulses), 96'd2);
      // Latest-wins pending buffer: B is overwritten by C while A is in flight.
      loop = 1'b1;
      txq.delete();
      wa = {1'b0, 89'h1_0000_0000_0000_0000_00AA};
      wb = {1'b1, 89'h0_BBBB_BBBB_BBBB_BBBB_BBBB};
      wc = {1'b1, 89'h0_0C0C_0C0C_0C0C_0C0C_0C0C};
      exp_q.push_back(wa);
      exp_q.push_back(wc);
      strobe(wa);
      step(2);
      strobe(wb);
      step(3);
      strobe(wc);
      wait_bytes(28, 200);
      step(30);
      chk("abc_byte_total", 96'(txq.size()), 96'd28);
      chk_frame(0, wa);
      chk_frame(14, wc);
      chk("abc_pulses", 96'(pulses), 96'd4);
      // Back-pressure mid-frame, then timeout measured from the resulting pulse.
      txq.delete();
      wd = {1'b0, 89'h0_DDDD_0000_FFFF_1111_2222};
      exp_q.push_back(wd);
      strobe(wd);
      for (int i = 0; i < 50 && txq.size() < 5; i++) step(1);
      tx_ready = 1'b0;
      b0 = tx_byte;
      v0 = tx_valid;
      changed = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (tx_byte !== b0 || tx_valid !== v0) changed = 1'b1;
      end
      chk("stall_valid_held", 96'(v0), 96'd1);
      chk("stall_stable", 96'(changed), 96'd0);
      tx_ready = 1'b1;
      for (int i = 0; i < 100 && ovalid !== 1'b1; i++) @(negedge clk);
      chk("stall_pulse_seen", 96'(ovalid), 96'd1);
      n = 0;
      while (n < 300 && link_up === 1'b1) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 96'(n), 96'd100);
      chk_frame(0, wd);
      @(posedge clk);
      #1;
      // Reset in the middle of a received frame.
      loop = 1'b0;
      p5 = {6'b0, 1'b1, 89'h0_0102_0304_0506_0708_090B};
      n = pulses;
      send(p5, 5, 1'b0);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("midrst_pulses", 96'(pulses), 96'(n));
      chk("midrst_odata", 96'(odata), 96'(DATA_T_DEFAULT));
      chk("midrst_link_up", 96'(link_up), 96'd0);
`ifdef SYNC_ERR_CNT_EN
      chk("midrst_err_cnt", 96'(err_cnt), 96'd0);
`endif
      exp_q.push_back(p5[89:0]);
      send(p5, 14, 1'b0);
      step(3);
      chk("postrst_pulses", 96'(pulses), 96'(n + 1));
      chk("postrst_link_up", 96'(link_up), 96'd1);
      chk("scoreboard_drained", 96'(exp_q.size()), 96'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/match_link_syncer.md
Name: match_link_syncer

Overview:
- Sits directly downstream of the action FSM and exchanges game state between the two player boards.
- TX side: packs the local player data word and scored flag into a framed byte stream for an external byte-level link transmitter.
- RX side: deframes the opponent's byte stream, checks it, and emits the opponent data word, scored flag and one-cycle valid strobe that the action FSM consumes.
- Also reports link liveness.

Parameters:
- TIMEOUT_CYCLES, 24'd2_500_000, cycles without a good frame before link_up_out drops.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk_pixel_in  input  1  pixel clock
- rst_in  input  1  reset
- player_data_in  input  data_t (89)  local player state from the action FSM
- player_scored_in  input  1  local scored flag
- player_data_valid_in  input  1  one-cycle strobe; latch player_data_in and player_scored_in
- tx_byte_out  output  8  byte to link transmitter
- tx_valid_out  output  1  tx_byte_out valid
- tx_ready_in  input  1  transmitter accepts the byte when tx_valid_out && tx_ready_in
- rx_byte_in  input  8  byte from link receiver
- rx_valid_in  input  1  one-cycle strobe per received byte
- opponent_data_out  output  data_t  last good opponent data
- opponent_scored_out  output  1  scored flag of last good frame
- syncer_out_valid  output  1  one-cycle pulse per accepted frame
- link_up_out  output  1  a good frame was received within TIMEOUT_CYCLES

Behaviour:
- Clock and reset: single clock clk_pixel_in. rst_in is synchronous, active-high.
- Reset values:
  - tx_valid_out=0, tx_byte_out=0.
  - opponent_data_out=DATA_T_DEFAULT, opponent_scored_out=0.
  - syncer_out_valid=0, link_up_out=0.
  - Pending buffer empty; both FSMs idle; timeout counter=0.
- Frame format: 14 bytes.
  - SYNC_BYTE first.
  - 12 payload bytes: 96-bit word = {6'b0, scored, data[88:0]}, least-significant byte first.
  - XOR checksum of the 12 payload bytes last.
- TX pending buffer:
  - player_data_valid_in writes a 90-bit pending buffer and sets pending=1.
  - A write while pending=1 overwrites the buffer (latest wins; no queueing).
- TX FSM, states TX_IDLE, TX_SEND, TX_CSUM:
  - TX_IDLE: if pending, copy pending to the shift register, clear pending, set byte index=0, present SYNC_BYTE, go to TX_SEND.
  - TX_SEND: advance on each handshake; bytes 1..12 are payload; then go to TX_CSUM.
  - TX_CSUM: present the checksum; on handshake go to TX_IDLE.
  - tx_byte_out and tx_valid_out stay stable while tx_ready_in=0.
  - A player_data_valid_in arriving mid-frame never corrupts the frame in flight.
  - Minimum one idle cycle between frames.
- RX FSM, states RX_HUNT, RX_PAYLOAD, RX_CHECK. Bytes are consumed only on rx_valid_in.
  - RX_HUNT: discard bytes until SYNC_BYTE; then clear the running XOR and go to RX_PAYLOAD.
  - RX_PAYLOAD: shift in 12 bytes while accumulating XOR. Any value, including SYNC_BYTE, is treated as data.
  - RX_CHECK: the next byte is compared to the accumulated XOR. Result:
    - Match and pad bits zero: good frame.
    - Otherwise: bad frame, dropped.
    - Either way, return to RX_HUNT.
- Good frame handling:
  - Update opponent_data_out and opponent_scored_out on the cycle after the checksum byte.
  - Pulse syncer_out_valid for exactly 1 cycle, coincident with the updated outputs.
  - Set link_up_out=1 and clear the timeout counter.
- Bad frame handling: outputs unchanged, no pulse.
- Timeout:
  - The counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES forces link_up_out=0.
- Simultaneous events: TX and RX are fully independent. Simultaneous good frame and counter saturation resolves as good frame wins.
- Reset mid-frame: both FSMs abort immediately to idle/hunt; the partial frame is discarded and the pending buffer cleared.

Optional Feature:
- Macro: SYNC_ERR_CNT_EN.
- Defined:
  - Adds output rx_err_count_out[15:0], reset 0.
  - Increments, saturating at 16'hFFFF, on every bad frame, including nonzero pad bits.
- Undefined: the port and counter do not exist; bad frames are silently dropped.

Decomposition:
- Package types.svh holds: data_t, DATA_T_DEFAULT, FRAME_BYTES=14, PAYLOAD_BYTES=12, and the tx_state_t and rx_state_t enums.
- One natural sub-module: frame_deframer, containing the RX FSM, XOR accumulator and payload shift register.
- TX, pending buffer and timeout logic stay in the top module.

Test Plan:
- Loopback (tx_byte_out to rx_byte_in, tx_ready_in=1), strobe data=DATA_T_DEFAULT^89'h1 with scored=1:
  - TX emits 14 bytes starting with 8'hA5.
  - syncer_out_valid pulses once, opponent_data_out = the sent word, opponent_scored_out=1, link_up_out=1.
- Inject a frame with the checksum byte flipped:
  - No pulse, outputs hold their previous values.
  - rx_err_count_out=1 with SYNC_ERR_CNT_EN.
- Strobe three updates A, B, C, with B and C issued while frame A is in flight:
  - Exactly two frames go out, A then C.
  - B never appears.
- Hold tx_ready_in=0 for 20 cycles mid-frame: tx_byte_out and tx_valid_out stay constant; the frame completes intact afterwards.
- TIMEOUT_CYCLES=100 with one good frame then silence: link_up_out falls exactly 100 cycles after the syncer_out_valid pulse.
- Assert rst_in after 5 RX bytes, then send a full valid frame: no pulse from the partial frame, and exactly one pulse from the full frame.
